// File: rtl/game_referee.sv
// Two-player k-in-a-row referee: accepts moves over valid/ready, rejects illegal ones,
// then scans the four lines through the placed stone, one direction per cycle.
module game_referee #(
  parameter int SIZE    = 3,
  parameter int WIN_LEN = 3,
  parameter int X_FIRST = 1,
  localparam int IDX_W  = ($clog2(SIZE) > 1) ? $clog2(SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   new_game,
  input  logic                   move_valid,
  input  logic [IDX_W-1:0]       move_row,
  input  logic [IDX_W-1:0]       move_col,
  output logic                   move_ready,
  output logic                   turn_o,
  output logic [SIZE*SIZE-1:0]   board_x,
  output logic [SIZE*SIZE-1:0]   board_o,
  output logic                   illegal,
  output logic                   win_x,
  output logic                   win_o,
  output logic                   draw
);

  localparam int N     = SIZE * SIZE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [N-1:0]     ONE    = N'(1);
  localparam logic [IDX_W:0]   SIZE_L = (IDX_W + 1)'(SIZE);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(N);
  localparam logic             TURN0  = (X_FIRST == 0);

  typedef enum logic [1:0] {S_WAIT, S_CHECK, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [IDX_W-1:0]   row_q, row_d, col_q, col_d;
  logic [N-1:0]       bx_q, bx_d, bo_q, bo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               turn_q, turn_d, hit_q, hit_d, ill_q, ill_d;
  logic               wx_q, wx_d, wo_q, wo_d, draw_q, draw_d;

  logic               in_range, occupied, line_hit, hit_now;
  logic [N-1:0]       cell_oh;

  // Off-board coordinates read as empty so the line scan clips at the edges.
  function automatic logic cell_set(input logic [N-1:0] b, input int r, input int c);
    logic [N-1:0] s;
    if (r < 0 || c < 0 || r >= SIZE || c >= SIZE) return 1'b0;
    s = b >> (r * SIZE + c);
    return s[0];
  endfunction

  assign in_range = ({1'b0, move_row} < SIZE_L) && ({1'b0, move_col} < SIZE_L);
  assign cell_oh  = in_range ? (ONE << (int'(move_row) * SIZE + int'(move_col))) : '0;
  assign occupied = |((bx_q | bo_q) & cell_oh);

  // Count the mover's run through the latched cell along the current direction.
  always_comb begin
    logic [N-1:0] mine;
    int dr, dc;
    int unsigned run;
    logic fwd, bwd;
    mine = turn_q ? bo_q : bx_q;
    dr   = (dir_q == 2'd0) ? 0 : 1;
    dc   = (dir_q == 2'd1) ? 0 : ((dir_q == 2'd3) ? -1 : 1);
    run  = 1;
    fwd  = 1'b1;
    bwd  = 1'b1;
    for (int unsigned k = 1; k < WIN_LEN; k++) begin
      fwd = fwd && cell_set(mine, int'(row_q) + dr * int'(k), int'(col_q) + dc * int'(k));
      bwd = bwd && cell_set(mine, int'(row_q) - dr * int'(k), int'(col_q) - dc * int'(k));
      if (fwd) run++;
      if (bwd) run++;
    end
    line_hit = (run >= unsigned'(WIN_LEN));
  end

  assign hit_now = hit_q | line_hit;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    bx_d    = bx_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;
    hit_d   = hit_q;
    ill_d   = 1'b0;
    wx_d    = wx_q;
    wo_d    = wo_q;
    draw_d  = draw_q;
    case (state_q)
      S_WAIT: begin
        if (move_valid) begin
          if (!in_range || occupied) begin
            ill_d = 1'b1;
          end else begin
            if (turn_q) bo_d = bo_q | cell_oh;
            else        bx_d = bx_q | cell_oh;
            cnt_d   = cnt_q + CNT_W'(1);
            row_d   = move_row;
            col_d   = move_col;
            dir_d   = 2'd0;
            hit_d   = 1'b0;
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        hit_d = hit_now;
        dir_d = dir_q + 2'd1;
        if (dir_q == 2'd3) begin
          if (hit_now) begin
            if (turn_q) wo_d = 1'b1;
            else        wx_d = 1'b1;
            state_d = S_OVER;
          end else if (cnt_q == FULL) begin
            draw_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_WAIT;
          end
        end
      end
      S_OVER:  ;
      default: state_d = S_WAIT;
    endcase
    if (new_game) begin
      state_d = S_WAIT;
      dir_d   = 2'd0;
      row_d   = '0;
      col_d   = '0;
      bx_d    = '0;
      bo_d    = '0;
      cnt_d   = '0;
      turn_d  = TURN0;
      hit_d   = 1'b0;
      ill_d   = 1'b0;
      wx_d    = 1'b0;
      wo_d    = 1'b0;
      draw_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      dir_q   <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
      bx_q    <= '0;
      bo_q    <= '0;
      cnt_q   <= '0;
      turn_q  <= TURN0;
      hit_q   <= 1'b0;
      ill_q   <= 1'b0;
      wx_q    <= 1'b0;
      wo_q    <= 1'b0;
      draw_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bx_q    <= bx_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      hit_q   <= hit_d;
      ill_q   <= ill_d;
      wx_q    <= wx_d;
      wo_q    <= wo_d;
      draw_q  <= draw_d;
    end
  end

  assign move_ready = (state_q == S_WAIT);
  assign turn_o     = turn_q;
  assign board_x    = bx_q;
  assign board_o    = bo_q;
  assign illegal    = ill_q;
  assign win_x      = wx_q;
  assign win_o      = wo_q;
  assign draw       = draw_q;

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: a 3x3/3 and a 5x5/4 referee checked every cycle against a
// board-scanning model, plus literal expectations for the directed scenarios.
module tb_game_referee;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       ng [2] = '{1'b0, 1'b0};
  logic       mv [2] = '{1'b0, 1'b0};
  logic [2:0] mr [2] = '{3'd0, 3'd0};
  logic [2:0] mc [2] = '{3'd0, 3'd0};
  logic rdy [2], trn [2], ill [2], wx [2], wo [2], dw [2];
  logic [8:0]  bx3, bo3;
  logic [24:0] bx5, bo5;

  int n_chk  = 0;
  int n_fail = 0;

  game_referee #(.SIZE(3), .WIN_LEN(3), .X_FIRST(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .new_game(ng[0]), .move_valid(mv[0]),
    .move_row(mr[0][1:0]), .move_col(mc[0][1:0]), .move_ready(rdy[0]), .turn_o(trn[0]),
    .board_x(bx3), .board_o(bo3), .illegal(ill[0]), .win_x(wx[0]), .win_o(wo[0]), .draw(dw[0]));

  game_referee #(.SIZE(5), .WIN_LEN(4), .X_FIRST(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .new_game(ng[1]), .move_valid(mv[1]),
    .move_row(mr[1]), .move_col(mc[1]), .move_ready(rdy[1]), .turn_o(trn[1]),
    .board_x(bx5), .board_o(bo5), .illegal(ill[1]), .win_x(wx[1]), .win_o(wo[1]), .draw(dw[1]));

  // Model: cell grid (0 empty, 1 X, 2 O), a check countdown, and the expected flags.
  int SZ [2] = '{3, 5};
  int WL [2] = '{3, 4};
  int g [2][8][8];
  int m_turn [2], m_busy [2], m_moves [2], m_over [2];
  int m_ill [2], m_wx [2], m_wo [2], m_dw [2];

  function automatic void m_clear(input int i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) g[i][r][c] = 0;
    m_turn[i] = 0; m_busy[i] = 0; m_moves[i] = 0; m_over[i] = 0;
    m_ill[i] = 0; m_wx[i] = 0; m_wo[i] = 0; m_dw[i] = 0;
  endfunction

  function automatic bit has_line(input int i, input int p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < SZ[i]; r++)
      for (int c = 0; c < SZ[i]; c++)
        for (int d = 0; d < 4; d++) begin
          int n = 0;
          for (int k = 0; k < WL[i]; k++) begin
            int rr = r + dr[d] * k;
            int cc = c + dc[d] * k;
            if (rr >= 0 && rr < SZ[i] && cc >= 0 && cc < SZ[i] && g[i][rr][cc] == p) n++;
          end
          if (n == WL[i]) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_board(input int i, input int p);
    logic [63:0] v = '0;
    for (int r = 0; r < SZ[i]; r++)
      for (int c = 0; c < SZ[i]; c++)
        if (g[i][r][c] == p) v = v | (64'd1 << (r * SZ[i] + c));
    return v;
  endfunction

  function automatic void m_step(input int i);
    m_ill[i] = 0;
    if (ng[i]) begin m_clear(i); return; end
    if (m_over[i] != 0) return;
    if (m_busy[i] > 0) begin
      m_busy[i]--;
      if (m_busy[i] == 0) begin
        if (has_line(i, m_turn[i] + 1)) begin
          if (m_turn[i] == 0) m_wx[i] = 1; else m_wo[i] = 1;
          m_over[i] = 1;
        end else if (m_moves[i] == SZ[i] * SZ[i]) begin
          m_dw[i] = 1; m_over[i] = 1;
        end else begin
          m_turn[i] = 1 - m_turn[i];
        end
      end
      return;
    end
    if (mv[i]) begin
      int r = int'(mr[i]);
      int c = int'(mc[i]);
      if (r >= SZ[i] || c >= SZ[i] || g[i][r][c] != 0) m_ill[i] = 1;
      else begin
        g[i][r][c] = m_turn[i] + 1;
        m_moves[i]++;
        m_busy[i] = 4;
      end
    end
  endfunction

  initial begin
    m_clear(0); m_clear(1);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin m_clear(0); m_clear(1); end
      else begin m_step(0); m_step(1); end
    end
  end

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) at %0t: got 0x%0h, expected 0x%0h", nm, i, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] act_bx(input int i);
    return (i == 0) ? 64'(bx3) : 64'(bx5);
  endfunction
  function automatic logic [63:0] act_bo(input int i);
    return (i == 0) ? 64'(bo3) : 64'(bo5);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("ready",   i, 64'(rdy[i]), 64'(m_over[i] == 0 && m_busy[i] == 0));
        chk("turn",    i, 64'(trn[i]), 64'(m_turn[i]));
        chk("board_x", i, act_bx(i),   m_board(i, 1));
        chk("board_o", i, act_bo(i),   m_board(i, 2));
        chk("illegal", i, 64'(ill[i]), 64'(m_ill[i]));
        chk("win_x",   i, 64'(wx[i]),  64'(m_wx[i]));
        chk("win_o",   i, 64'(wo[i]),  64'(m_wo[i]));
        chk("draw",    i, 64'(dw[i]),  64'(m_dw[i]));
      end
    end
  end

  task automatic play(input int i, input int r, input int c);
    int w = 0;
    while (rdy[i] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (rdy[i] !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout (dut%0d): ready=%b, required 1", i, rdy[i]);
    end
    mv[i] = 1'b1; mr[i] = 3'(r); mc[i] = 3'(c);
    @(negedge clk);
    mv[i] = 1'b0;
  endtask

  task automatic newgame(input int i);
    ng[i] = 1'b1;
    @(negedge clk);
    ng[i] = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, 64'(rdy[0]), 64'd1);
    chk("rst_turn",  0, 64'(trn[0]), 64'd0);
    chk("rst_bx",    0, 64'(bx3),    64'd0);

    // Top-row win for X; flag appears on the fifth cycle after the last handshake.
    play(0, 0, 0); play(0, 1, 0); play(0, 0, 1); play(0, 1, 1); play(0, 0, 2);
    repeat (3) @(negedge clk);
    chk("t1_win_early", 0, 64'(wx[0]), 64'd0);
    @(negedge clk);
    chk("t1_win_x", 0, 64'(wx[0]),  64'd1);
    chk("t1_bx",    0, 64'(bx3),    64'h007);
    chk("t1_bo",    0, 64'(bo3),    64'h018);
    chk("t1_ready", 0, 64'(rdy[0]), 64'd0);
    mv[0] = 1'b1; mr[0] = 3'd0; mc[0] = 3'd0;
    repeat (2) @(negedge clk);
    mv[0] = 1'b0;
    chk("over_no_illegal", 0, 64'(ill[0]), 64'd0);

    // Occupied cell is rejected with a single-cycle pulse.
    newgame(0);
    play(0, 1, 1); play(0, 1, 1);
    chk("t2_illegal", 0, 64'(ill[0]), 64'd1);
    chk("t2_bo",      0, 64'(bo3),    64'd0);
    @(negedge clk);
    chk("t2_pulse_end", 0, 64'(ill[0]), 64'd0);
    chk("t2_turn",      0, 64'(trn[0]), 64'd1);
    chk("t2_ready",     0, 64'(rdy[0]), 64'd1);

    // Full board with no line.
    newgame(0);
    play(0, 0, 0); play(0, 0, 1); play(0, 0, 2); play(0, 1, 1); play(0, 1, 0);
    play(0, 1, 2); play(0, 2, 1); play(0, 2, 0); play(0, 2, 2);
    repeat (4) @(negedge clk);
    chk("t3_draw", 0, 64'(dw[0]), 64'd1);
    chk("t3_wx",   0, 64'(wx[0]), 64'd0);
    chk("t3_wo",   0, 64'(wo[0]), 64'd0);
    chk("t3_bx",   0, 64'(bx3),   64'h18D);
    chk("t3_bo",   0, 64'(bo3),   64'h072);

    // 5x5, four on the anti-diagonal.
    newgame(1);
    play(1, 0, 4); play(1, 0, 0); play(1, 1, 3); play(1, 4, 4);
    play(1, 2, 2); play(1, 4, 0); play(1, 3, 1);
    repeat (4) @(negedge clk);
    chk("t4_win_x", 1, 64'(wx[1]), 64'd1);
    chk("t4_wo",    1, 64'(wo[1]), 64'd0);
    chk("t4_bx",    1, 64'(bx5),   64'h11110);

    // Out-of-range row, then new_game racing a legal move.
    newgame(1);
    play(1, 5, 0);
    chk("t5_illegal", 1, 64'(ill[1]), 64'd1);
    chk("t5_bx",      1, 64'(bx5),    64'd0);
    ng[1] = 1'b1; mv[1] = 1'b1; mr[1] = 3'd2; mc[1] = 3'd2;
    @(negedge clk);
    ng[1] = 1'b0; mv[1] = 1'b0;
    chk("t5_ng_bx",    1, 64'(bx5),    64'd0);
    chk("t5_ng_bo",    1, 64'(bo5),    64'd0);
    chk("t5_ng_ready", 1, 64'(rdy[1]), 64'd1);
    chk("t5_ng_turn",  1, 64'(trn[1]), 64'd0);
    repeat (5) @(negedge clk);

    // Reset during the second check cycle of a winning move.
    newgame(0);
    play(0, 0, 0); play(0, 1, 0); play(0, 0, 1); play(0, 1, 1); play(0, 0, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_bx", 0, 64'(bx3),   64'd0);
    chk("t6_rst_bo", 0, 64'(bo3),   64'd0);
    chk("t6_rst_wx", 0, 64'(wx[0]), 64'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_after_wx", 0, 64'(wx[0]), 64'd0);
    chk("t6_after_bx", 0, 64'(bx3),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
